// File: rtl/ec2_control_unit.sv
// ec2_control_unit: fetch/decode/execute FSM for the EC-2 accumulator datapath with Enter handshake and single-step mode
module ec2_control_unit #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Enter,
  input  logic       Step,
  input  logic       StepMode,
  input  logic [2:0] IR,
  input  logic       Aeq0,
  input  logic       Apos,
  output logic       IRload,
  output logic       JMPmux,
  output logic       PCload,
  output logic       Meminst,
  output logic       MemWr,
  output logic [1:0] Asel,
  output logic       Aload,
  output logic       Sub,
  output logic       Halt,
  output logic       InWait,
  output logic [3:0] state
);
  typedef enum logic [3:0] {
    START  = 4'b0000,
    FETCH  = 4'b0001,
    DECODE = 4'b0010,
    LOAD   = 4'b1000,
    STORE  = 4'b1001,
    ADD    = 4'b1010,
    SUB    = 4'b1011,
    INPUT  = 4'b1100,
    JZ     = 4'b1101,
    JPOS   = 4'b1110,
    HALT   = 4'b1111
  } state_t;
  state_t st;
  logic [SYNC_STAGES-1:0] enter_sync, step_sync;
  logic enter_hist, step_hist, enter_edge, step_edge, go;
  assign enter_edge = enter_sync[SYNC_STAGES-1] & ~enter_hist;
  assign step_edge  = step_sync[SYNC_STAGES-1] & ~step_hist;
  assign go         = ~StepMode | step_edge;
  assign state      = st;
  always_ff @(posedge Clock)
    if (!Reset) begin
      st         <= START;
      enter_sync <= '0;
      step_sync  <= '0;
      enter_hist <= 1'b0;
      step_hist  <= 1'b0;
    end else begin
      enter_sync <= {enter_sync[SYNC_STAGES-2:0], Enter};
      step_sync  <= {step_sync[SYNC_STAGES-2:0], Step};
      enter_hist <= enter_sync[SYNC_STAGES-1];
      step_hist  <= step_sync[SYNC_STAGES-1];
      if (st == INPUT) begin
        if (enter_edge) st <= START;
      end else if (st != HALT && go)
        // execute states share the opcode in their low three bits
        st <= st == START  ? FETCH :
              st == FETCH  ? DECODE :
              st == DECODE ? state_t'({1'b1, IR}) : START;
    end
  assign IRload  = st == FETCH & go;
  assign PCload  = (st == FETCH | (st == JZ & Aeq0) | (st == JPOS & Apos)) & go;
  assign JMPmux  = st == JZ | st == JPOS;
  assign Meminst = st inside {DECODE, LOAD, STORE, ADD, SUB};
  assign MemWr   = st == STORE & go;
  assign Asel    = st == LOAD ? 2'b10 : st == INPUT ? 2'b01 : 2'b00;
  assign Aload   = st == INPUT ? enter_edge : (st inside {LOAD, ADD, SUB}) & go;
  assign Sub     = st == SUB;
  assign Halt    = st == HALT;
  assign InWait  = st == INPUT;
endmodule

// File: tb/tb_ec2_control_unit.sv
// tb_ec2_control_unit: directed scoreboard bench for the EC-2 control unit
module tb_ec2_control_unit;
  logic Clock = 0, Reset = 0, Enter = 0, Step = 0, StepMode = 0, Aeq0 = 0, Apos = 0;
  logic [2:0] IR = 3'b000;
  logic IRload, JMPmux, PCload, Meminst, MemWr, Aload, Sub, Halt, InWait;
  logic [1:0] Asel;
  logic [3:0] state;
  int checks = 0, failures = 0;
  typedef struct { string tag; logic [14:0] v; } exp_t;
  exp_t q[$];
  // {state, IRload, JMPmux, PCload, Meminst, MemWr, Asel, Aload, Sub, Halt, InWait}
  localparam logic [14:0] S_START  = {4'b0000, 11'b00000000000};
  localparam logic [14:0] S_FETCH  = {4'b0001, 11'b10100000000};
  localparam logic [14:0] S_FETCHG = {4'b0001, 11'b00000000000};
  localparam logic [14:0] S_DECODE = {4'b0010, 11'b00010000000};
  localparam logic [14:0] S_LOAD   = {4'b1000, 11'b00010101000};
  localparam logic [14:0] S_LOADG  = {4'b1000, 11'b00010100000};
  localparam logic [14:0] S_STORE  = {4'b1001, 11'b00011000000};
  localparam logic [14:0] S_ADD    = {4'b1010, 11'b00010001000};
  localparam logic [14:0] S_SUB    = {4'b1011, 11'b00010001100};
  localparam logic [14:0] S_JZ1    = {4'b1101, 11'b01100000000};
  localparam logic [14:0] S_JZ0    = {4'b1101, 11'b01000000000};
  localparam logic [14:0] S_JP1    = {4'b1110, 11'b01100000000};
  localparam logic [14:0] S_JP0    = {4'b1110, 11'b01000000000};
  localparam logic [14:0] S_INW    = {4'b1100, 11'b00000010001};
  localparam logic [14:0] S_INL    = {4'b1100, 11'b00000011001};
  localparam logic [14:0] S_HALT   = {4'b1111, 11'b00000000010};
  wire [14:0] obs = {state, IRload, JMPmux, PCload, Meminst, MemWr, Asel, Aload, Sub, Halt, InWait};

  ec2_control_unit #(.SYNC_STAGES(2)) dut (
    .Clock(Clock), .Reset(Reset), .Enter(Enter), .Step(Step), .StepMode(StepMode),
    .IR(IR), .Aeq0(Aeq0), .Apos(Apos), .IRload(IRload), .JMPmux(JMPmux),
    .PCload(PCload), .Meminst(Meminst), .MemWr(MemWr), .Asel(Asel), .Aload(Aload),
    .Sub(Sub), .Halt(Halt), .InWait(InWait), .state(state)
  );

  always #5 Clock = ~Clock;

  always @(negedge Clock)
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      assert (obs === e.v) else begin
        failures++;
        $error("FAIL %s observed=%b expected=%b", e.tag, obs, e.v);
      end
    end

  task automatic nx();
    @(posedge Clock);
    #1;
  endtask

  task automatic ex(input string tag, input logic [14:0] v);
    exp_t e;
    e.tag = tag;
    e.v = v;
    q.push_back(e);
  endtask

  task automatic instr(input logic [2:0] op, input logic [14:0] exv, input string tag);
    IR = op;
    nx(); ex({tag, "_fetch"}, S_FETCH);
    nx(); ex({tag, "_decode"}, S_DECODE);
    nx(); ex(tag, exv);
    nx(); ex({tag, "_start"}, S_START);
  endtask

  task automatic pstep(input logic [14:0] a, input logic [14:0] b, input logic [14:0] c, input string tag);
    Step = 1;
    nx(); ex({tag, "_wait"}, a);
    nx(); ex({tag, "_edge"}, b);
    Step = 0;
    nx(); ex({tag, "_next"}, c);
  endtask

  initial begin
    nx(); ex("rst0", S_START);
    nx(); ex("rst1", S_START);
    Reset = 1;
    instr(3'b000, S_LOAD, "load");
    instr(3'b001, S_STORE, "store");
    instr(3'b010, S_ADD, "add");
    instr(3'b011, S_SUB, "sub");
    Aeq0 = 1; instr(3'b101, S_JZ1, "jz_taken");
    Aeq0 = 0; instr(3'b101, S_JZ0, "jz_not");
    Apos = 1; instr(3'b110, S_JP1, "jpos_taken");
    Apos = 0; instr(3'b110, S_JP0, "jpos_not");
    // INPUT: wait, then one Enter press
    IR = 3'b100;
    nx(); ex("in_fetch", S_FETCH);
    nx(); ex("in_decode", S_DECODE);
    for (int i = 0; i < 10; i++) begin nx(); ex("in_wait", S_INW); end
    Enter = 1;
    nx(); ex("in_sync", S_INW);
    nx(); ex("in_load", S_INL);
    nx(); ex("in_done", S_START);
    // Enter held through the next INPUT must not load
    nx(); ex("in2_fetch", S_FETCH);
    nx(); ex("in2_decode", S_DECODE);
    for (int i = 0; i < 5; i++) begin nx(); ex("in2_held", S_INW); end
    Enter = 0;
    for (int i = 0; i < 4; i++) begin nx(); ex("in2_release", S_INW); end
    Enter = 1;
    nx(); ex("in2_sync", S_INW);
    nx(); ex("in2_load", S_INL);
    nx(); ex("in2_done", S_START);
    Enter = 0;
    // HALT absorbs Step and Enter
    instr(3'b111, S_HALT, "halt");
    q.delete(q.size() - 1);
    for (int i = 0; i < 20; i++) begin
      Step = i[1]; Enter = i[2];
      nx(); ex("halt_hold", S_HALT);
    end
    Step = 0; Enter = 0; Reset = 0;
    nx(); ex("halt_reset", S_START);
    Reset = 1;
    // reset during INPUT wait
    IR = 3'b100;
    nx(); ex("rin_fetch", S_FETCH);
    nx(); ex("rin_decode", S_DECODE);
    nx(); ex("rin_wait", S_INW);
    Reset = 0;
    nx(); ex("rin_reset", S_START);
    Reset = 1;
    nx(); ex("rin_fetch2", S_FETCH);
    IR = 3'b000;
    nx(); ex("rin_decode2", S_DECODE);
    nx(); ex("rin_load", S_LOAD);
    nx(); ex("rin_start", S_START);
    // single-step mode
    StepMode = 1;
    for (int i = 0; i < 15; i++) begin nx(); ex("step_frozen", S_START); end
    pstep(S_START, S_START, S_FETCHG, "step_start");
    for (int i = 0; i < 5; i++) begin nx(); ex("step_fetch_hold", S_FETCHG); end
    pstep(S_FETCHG, S_FETCH, S_DECODE, "step_fetch");
    pstep(S_DECODE, S_DECODE, S_LOADG, "step_decode");
    pstep(S_LOADG, S_LOAD, S_START, "step_load");
    StepMode = 0;
    nx(); ex("run_fetch", S_FETCH);
    @(negedge Clock);
    #1;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain observed=%0d expected=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ec2_control_unit.md
Name: ec2_control_unit

Overview:
Control-unit FSM for the EC-2 8-bit accumulator datapath: IR, PC, A, 32x8 memory, add/sub unit and A input mux. It fetches, decodes and executes one instruction at a time. It drives every datapath control line that is otherwise set by hand on the switches. It adds a synchronized Enter handshake for the INPUT instruction and a single-step debug mode.

Parameters:
SYNC_STAGES, 2, depth of the flop synchronizer on Enter and Step (legal 2..4).

Ports:
Clock  in  1  system clock, rising edge.
Reset  in  1  synchronous, active-low reset.
Enter  in  1  asynchronous push-button level; confirms the INPUT instruction.
Step  in  1  asynchronous push-button level; advances one state in step mode.
StepMode  in  1  1 = single-step, 0 = free run. Treated as quasi-static, not synchronized.
IR  in  3  opcode field IR[7:5] from the datapath.
Aeq0  in  1  A == 0 flag.
Apos  in  1  A > 0 flag (A[7]==0 and A!=0).
IRload  out  1  load IR from memory data.
JMPmux  out  1  0 = PC+1, 1 = IR[4:0] into PC.
PCload  out  1  load PC.
Meminst  out  1  memory address select: 0 = PC, 1 = IR[4:0].
MemWr  out  1  memory write strobe (data = A).
Asel  out  2  A source: 00 = add/sub result, 01 = Input, 10 = memory data, 11 = unused.
Aload  out  1  load A.
Sub  out  1  1 = subtract.
Halt  out  1  processor halted.
InWait  out  1  waiting for Enter in the INPUT state.
state  out  4  current state code, for LED display.

Behaviour:
- State codes: START 0000, FETCH 0001, DECODE 0010, LOAD 1000, STORE 1001, ADD 1010, SUB 1011, INPUT 1100, JZ 1101, JPOS 1110, HALT 1111.
- Opcodes: 000 LOAD, 001 STORE, 010 ADD, 011 SUB, 100 INPUT, 101 JZ, 110 JPOS, 111 HALT.
- Reset:
  - Reset==0 at a rising edge puts state in START and clears all synchronizer and edge flops.
  - Reset wins over every other event, including mid-INPUT wait and HALT.
  - All outputs are Moore-decoded from state, so every output is 0 while in START.
- Default output value is 0 unless listed below.
  - START: no outputs. Next state FETCH.
  - FETCH: Meminst=0, IRload=1, PCload=1, JMPmux=0. Next state DECODE.
  - DECODE: Meminst=1. Next state = execute state selected by IR.
  - LOAD: Meminst=1, Asel=10, Aload=1. Next state START.
  - STORE: Meminst=1, MemWr=1. Next state START.
  - ADD: Meminst=1, Asel=00, Sub=0, Aload=1. Next state START.
  - SUB: Meminst=1, Asel=00, Sub=1, Aload=1. Next state START.
  - JZ: JMPmux=1, PCload=Aeq0. Next state START.
  - JPOS: JMPmux=1, PCload=Apos. Next state START.
  - INPUT: Asel=01, InWait=1, Aload=enter_edge. Stays in INPUT until enter_edge, then START.
  - HALT: Halt=1. Absorbing state; Enter and Step are ignored; only Reset exits.
- Synchronizers: Enter and Step each pass through SYNC_STAGES flops plus one history flop.
  - edge = last sync stage & ~history flop.
  - edge is high for exactly one cycle per press, no matter how long the button is held.
  - Enter first sampled high at edge k → enter_edge high in the cycle after edge k+SYNC_STAGES-1 → A loads and state goes to START at edge k+SYNC_STAGES.
  - Enter already high when INPUT is entered does not load A. A new 0→1 edge is required, unless that edge is still in flight in the synchronizer.
- Step mode (StepMode==1):
  - Applies to every state except INPUT and HALT.
  - State advances only in a cycle where step_edge==1.
  - IRload, PCload, Aload and MemWr are gated to 0 in cycles where step_edge==0. Mux selects (JMPmux, Meminst, Asel, Sub) stay at their state values.
  - INPUT is gated by Enter only; step_edge is ignored there.
  - Step and Enter edges in the same cycle in INPUT: Enter acts, Step is discarded.
- StepMode changing mid-instruction takes effect at the next clock edge. The state path is unaffected otherwise.
- Outputs are glitch-free state decodes. The exceptions are PCload in JZ/JPOS, which follows the flags, and the strobes gated by edge signals; these are combinational but have no output flops.

Test Plan:
1. Reset low 2 edges, StepMode=0, IR=000 → state 0000,0001,0010,1000,0000. FETCH cycle: IRload=PCload=1, Meminst=0. LOAD cycle: Asel=10, Aload=1, Meminst=1. All outputs 0 during reset.
2. IR=001, then 010, then 011 → STORE cycle: MemWr=1, Aload=0. ADD cycle: Asel=00, Sub=0, Aload=1. SUB cycle: Sub=1, Aload=1. Each instruction takes 4 cycles.
3. IR=101 with Aeq0=1 → JZ cycle JMPmux=1, PCload=1; repeat with Aeq0=0 → PCload=0. IR=110 with Apos=1/0 → PCload=1/0.
4. IR=100, Enter low 10 cycles → state held at 1100, InWait=1, Aload=0. Raise Enter at edge k → Aload=1 for exactly one cycle, state=0000 at edge k+2. Hold Enter high through the next INPUT → no load until Enter is released and re-pressed.
5. IR=111 → Halt=1 for 20+ cycles, Step/Enter toggled with no effect. Reset low at one edge → state 0000, Halt=0. Reset asserted mid-INPUT wait → START next edge.
6. StepMode=1, no Step for 15 cycles → state frozen, no strobes. Each Step press → exactly one state advance, with IRload/PCload high only in the edge cycle of FETCH.
